jpeg_spi_rx_capture: RTL

JPEG_SPI_RX_CAPTURE -- requirements
Module: jpeg_spi_rx_capture

---
 rtl/jpeg_spi_rx_capture_if.sv | 19 +
 rtl/jpeg_spi_rx_capture.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/jpeg_spi_rx_capture_if.sv
// Byte-stream input and capture-buffer write port of the JPEG SPI receive capture block.
// The master side drives the SPI byte strobe; the slave side owns the buffer write port.
interface jpeg_spi_rx_capture_if;
    logic        spi_wr;
    logic [7:0]  spi_data;
    logic        buf_we;
    logic [16:0] buf_addr;
    logic [7:0]  buf_data;

    modport master (
        output spi_wr, spi_data,
        input  buf_we, buf_addr, buf_data
    );

    modport slave (
        input  spi_wr, spi_data,
        output buf_we, buf_addr, buf_data
    );
endinterface

// File: rtl/jpeg_spi_rx_capture.sv
// Captures one JPEG frame from a byte stream: 3 size bytes, then header+image bytes into a
// buffer until the EOI marker. Defining JPEG_RX_SIZE_CHECK_EN enables the err_size check.
module jpeg_spi_rx_capture #(
    parameter int          HEADER_SIZE = 607,
    parameter logic [15:0] EOI_MARKER  = 16'hFFD9,
    parameter int          BUF_DEPTH   = 131072
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    jpeg_spi_rx_capture_if.slave         spi_buf,
    output logic                         busy,
    output logic                         done,
    output logic                         err_overflow,
    output logic                         err_size,
    output logic [16:0]                  jpeg_size,
    output logic [16:0]                  byte_count
);

    typedef enum logic [2:0] {
        IDLE,
        SZ1,
        SZ2,
        SZ3,
        DATA,
        DONE,
        ERR
    } state_e;

    localparam logic [16:0] EOI_MIN_IDX = 17'(HEADER_SIZE + 1);
    localparam logic [16:0] LAST_IDX    = 17'(BUF_DEPTH - 1);
    localparam logic [17:0] HDR_LEN     = 18'(HEADER_SIZE);

    state_e      state_q, state_d;
    logic [16:0] byte_count_q, byte_count_d;
    logic [16:0] jpeg_size_q, jpeg_size_d;
    logic [7:0]  prev_q, prev_d;
    logic        err_size_q, err_size_d;
    logic        buf_we_q, buf_we_d;
    logic [16:0] buf_addr_q, buf_addr_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic        eoi_hit;

    // Full detection uses the pre-increment index, so a 17-bit count that wraps at the
    // default depth never hides the overflow.
    assign eoi_hit = (byte_count_q >= EOI_MIN_IDX)
                  && ({prev_q, spi_buf.spi_data} == EOI_MARKER);

    always_comb begin
        // NOTE: every *_d gets a default before any branch so no path can infer a latch.
        state_d      = state_q;
        byte_count_d = byte_count_q;
        jpeg_size_d  = jpeg_size_q;
        prev_d       = prev_q;
        err_size_d   = err_size_q;
        buf_we_d     = 1'b0;
        buf_addr_d   = buf_addr_q;
        buf_data_d   = buf_data_q;

        if (abort) begin
            state_d      = IDLE;
            byte_count_d = '0;
            jpeg_size_d  = '0;
            err_size_d   = 1'b0;
            prev_d       = '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_d      = SZ1;
                        byte_count_d = '0;
                        jpeg_size_d  = '0;
                        err_size_d   = 1'b0;
                        prev_d       = '0;
                    end
                end
                SZ1: begin
                    if (spi_buf.spi_wr) begin
                        jpeg_size_d = {spi_buf.spi_data[0], 16'h0000};
                        state_d     = SZ2;
`ifdef JPEG_RX_SIZE_CHECK_EN
                        if (|spi_buf.spi_data[7:1]) err_size_d = 1'b1;
`endif
                    end
                end
                SZ2: begin
                    if (spi_buf.spi_wr) begin
                        jpeg_size_d[15:8] = spi_buf.spi_data;
                        state_d           = SZ3;
                    end
                end
                SZ3: begin
                    if (spi_buf.spi_wr) begin
                        jpeg_size_d[7:0] = spi_buf.spi_data;
                        state_d          = DATA;
                    end
                end
                DATA: begin
                    if (spi_buf.spi_wr) begin
                        buf_we_d     = 1'b1;
                        buf_addr_d   = byte_count_q;
                        buf_data_d   = spi_buf.spi_data;
                        byte_count_d = byte_count_q + 17'd1;
                        prev_d       = spi_buf.spi_data;
                        // EOI wins over overflow when the marker lands on the last slot.
                        if (eoi_hit) begin
                            state_d = DONE;
`ifdef JPEG_RX_SIZE_CHECK_EN
                            if (({1'b0, byte_count_q} + 18'd1) != (HDR_LEN + {1'b0, jpeg_size_q}))
                                err_size_d = 1'b1;
`endif
                        end else if (byte_count_q == LAST_IDX) begin
                            state_d = ERR;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            byte_count_q <= '0;
            jpeg_size_q  <= '0;
            prev_q       <= '0;
            err_size_q   <= 1'b0;
            buf_we_q     <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            byte_count_q <= byte_count_d;
            jpeg_size_q  <= jpeg_size_d;
            prev_q       <= prev_d;
            err_size_q   <= err_size_d;
            buf_we_q     <= buf_we_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
        end
    end

    assign spi_buf.buf_we   = buf_we_q;
    assign spi_buf.buf_addr = buf_addr_q;
    assign spi_buf.buf_data = buf_data_q;

    assign busy         = (state_q == SZ1) || (state_q == SZ2)
                       || (state_q == SZ3) || (state_q == DATA);
    assign done         = (state_q == DONE);
    assign err_overflow = (state_q == ERR);
    assign jpeg_size    = jpeg_size_q;
    assign byte_count   = byte_count_q;

`ifdef JPEG_RX_SIZE_CHECK_EN
    assign err_size = err_size_q;
`else
    assign err_size = 1'b0;
`endif

endmodule
